sram_bist: RTL
==============

# sram_bist

Built-in memory tester that drives the SRAM controller's system-side request port (`mem`/`rw`/`addr`/`data_f2s`/`ready`). On `start` it:
- writes a selected data pattern over an inclusive address range;
- reads the range back through the controller's registered read-data output and compares each word against the expected pattern;
- reports pass/fail, a saturating error count and the first failing address and data word.

## Interface
- `ADDR_W`, 18, address width; matches the controller's `addr`.
- `DATA_W`, 16, data width; matches `data_f2s`/`data_s2f_r`.
- `CNT_W`, 16, width of the error counter.
- `clk`  in  1  single clock for the whole block.
- `reset`  in  1  asynchronous, active-high reset.
- `start`  in  1  one-cycle pulse; sampled only when not busy.
- `pattern`  in  2  pattern code: 00 = data is `addr[DATA_W-1:0]`; 01 = checkerboard (`16'h5555` for even addresses, `16'hAAAA` for odd); 10 = `~addr[DATA_W-1:0]`; 11 = constant `16'hFFFF`.
- `addr_lo`  in  ADDR_W  first address, inclusive.
- `addr_hi`  in  ADDR_W  last address, inclusive.
- `mem`  out  1  request valid, to the controller.
- `rw`  out  1  1 = read, 0 = write.
- `addr`  out  ADDR_W  request address.
- `data_f2s`  out  DATA_W  write data.
- `ready`  in  1  controller ready; a request is accepted at a rising edge where `mem` and `ready` are both 1.
- `data_s2f_r`  in  DATA_W  controller's registered read data.
- `busy`  out  1  test in progress.
- `done`  out  1  test finished; held until the next accepted `start`.
- `pass`  out  1  valid while `done`; 1 when `err_count` is 0.
- `err_count`  out  CNT_W  number of mismatched words; saturates at all-ones.
- `first_err_addr`  out  ADDR_W  address of the first mismatch.
- `first_err_data`  out  DATA_W  read data of the first mismatch.

## Operation
- **Reset values:** all outputs are registered.
  - `mem`=0, `rw`=1, `addr`=0, `data_f2s`=0.
  - `busy`=0, `done`=0, `pass`=0, `err_count`=0, `first_err_*`=0.
  - All internal state returns to IDLE.
- **IDLE:** on `start`, latch `pattern`, `addr_lo` and `addr_hi`, and clear `done`, `pass`, `err_count` and `first_err_*`.
  - If `addr_lo > addr_hi`: go to DONE with `pass`=1 and issue no requests.
  - Otherwise: go to WRITE with `busy`=1, `mem`=1, `rw`=0, `addr`=`addr_lo`, `data_f2s`=`exp(addr_lo)`.
- **WRITE:** on each accepted request, if `addr == addr_hi` switch to READ with `rw`=1 and `addr`=`addr_lo`; otherwise increment `addr` and present `exp(addr+1)`.
- **READ:**
  - On each accept, record `pend_addr`=`addr` and set `pend_valid`.
  - On the last address, drop `mem` to 0 and go to DRAIN.
  - Otherwise increment `addr`.
- **Read completion:** a read is complete at the first rising edge with `ready`=1 after its acceptance. At that edge:
  - set `cmp_valid`=1 and `cmp_addr`=`pend_addr`;
  - the next read may be accepted at the same edge, in which case `pend_addr` takes the new address.
- **Compare:** in the cycle after completion, compare `data_s2f_r` against `exp(cmp_addr)`.
  - On mismatch: increment `err_count` (saturating).
  - If this is the first mismatch: capture `first_err_addr`/`first_err_data`.
- **DRAIN:** wait for the last read to complete and its compare to retire. Then go to DONE with `busy`=0, `done`=1, `pass`=(`err_count`==0).
- **DONE:** behaves as IDLE for `start`.
- **`start` while busy:** ignored.
- **Address counter:** must not wrap. `addr_hi` = `2^ADDR_W-1` is legal, and termination is by equality compare, never by overflow.
- **Reset mid-test:** reset immediately returns every output to its reset value. The controller shares the same reset.

## Timing
- Assumes the controller's 2-cycle accesses. N = `addr_hi - addr_lo + 1`, and `start` is sampled at edge S.
- `mem` rises after edge S.
- Writes are accepted at S+1, S+3, …, S+2N-1.
- Reads are accepted at S+2N+1, …, S+4N-1.
- The last read completes at S+4N+1.
- `done` rises and `busy` falls at edge S+4N+2.
- Empty range: `done`=1 and `pass`=1 from edge S.
- `mem` is never low between accepts inside a phase, except after the final read.

## Structure
- Package `sram_bist_pkg` holds:
  - the state encoding: IDLE, WRITE, READ, DRAIN, DONE;
  - the pattern codes (`PAT_ADDR`, `PAT_CHECK`, `PAT_NADDR`, `PAT_ONES`);
  - the default widths.
- Sub-module `sram_bist_pattern`: a combinational function mapping (`pattern`, `addr`) to expected data. It is instantiated twice: once for write data and once for compare.

## Test plan
- Controller plus a correct SRAM model; range 0..3; `pattern`=00; `start` at S.
  - Required: 8 accepts at S+1…S+15 step 2.
  - Required: `done` at S+18, `pass`=1, `err_count`=0.
- Same setup, but the model forces bit 3 at address 2.
  - Required: `err_count`=1, `first_err_addr`=2, `first_err_data`=`16'h000A`, `pass`=0.
- `addr_lo`=5, `addr_hi`=4.
  - Required: `done` and `pass` from edge S; `mem` stays 0.
- Range `3FFFE`..`3FFFF`, `pattern`=11.
  - Required: exactly 2 writes then 2 reads, with no address wrap.
  - Required: `pass`=1, and `addr` never equals 0 during the test.
- `pattern`=01; assert `start` again mid-test; then assert `reset` during READ.
  - Required: the second `start` has no effect.
  - Required: after `reset`, all outputs are at reset values and `mem`=0.
- Stuck-at-0 model on every address, range 0..`FFFF`, `pattern`=11.
  - Required: `err_count` saturates at `16'hFFFF`.
  - Required: `first_err_addr`=0.

Source files
------------

// File: rtl/sram_bist_pkg.sv
// Shared constants for the SRAM built-in self test: widths, FSM encoding, pattern codes.
package sram_bist_pkg;

    localparam int ADDR_W_DEF = 18;
    localparam int DATA_W_DEF = 16;
    localparam int CNT_W_DEF  = 16;

    localparam int ST_W = 3;
    localparam logic [ST_W-1:0] ST_IDLE  = 3'd0;
    localparam logic [ST_W-1:0] ST_WRITE = 3'd1;
    localparam logic [ST_W-1:0] ST_READ  = 3'd2;
    localparam logic [ST_W-1:0] ST_DRAIN = 3'd3;
    localparam logic [ST_W-1:0] ST_DONE  = 3'd4;

    localparam logic [1:0] PAT_ADDR  = 2'b00;
    localparam logic [1:0] PAT_CHECK = 2'b01;
    localparam logic [1:0] PAT_NADDR = 2'b10;
    localparam logic [1:0] PAT_ONES  = 2'b11;

endpackage

// File: rtl/sram_bist_pattern.sv
// Expected data word for a given pattern code and address (low DATA_W address bits).
module sram_bist_pattern
    import sram_bist_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic [1:0]        pattern,
    input  logic [DATA_W-1:0] addr,
    output logic [DATA_W-1:0] data
);

    // Pattern decode; checkerboard sets even bits on even addresses, odd bits on odd ones.
    always_comb begin
        data = '0;
        case (pattern)
            PAT_ADDR:  data = addr;
            PAT_CHECK: begin
                for (int i = 0; i < DATA_W; i++) begin
                    data[i] = ((i % 2) == 0) ? ~addr[0] : addr[0];
                end
            end
            PAT_NADDR: data = ~addr;
            PAT_ONES:  data = '1;
            default:   data = '0;
        endcase
    end

endmodule

// File: rtl/sram_bist.sv
// SRAM built-in self test: write a pattern over a range, read it back, count mismatches.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | waiting for start, no requests issued
// WRITE    | issuing write requests lo..hi
// READ     | issuing read requests lo..hi, compares run in the shadow
// DRAIN    | last read issued, waiting for its compare to retire
// DONE     | results valid; start behaves as in IDLE
module sram_bist
    import sram_bist_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int CNT_W  = CNT_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [1:0]        pattern,
    input  logic [ADDR_W-1:0] addr_lo,
    input  logic [ADDR_W-1:0] addr_hi,
    output logic              mem,
    output logic              rw,
    output logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] data_f2s,
    input  logic              ready,
    input  logic [DATA_W-1:0] data_s2f_r,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [CNT_W-1:0]  err_count,
    output logic [ADDR_W-1:0] first_err_addr,
    output logic [DATA_W-1:0] first_err_data
);

    logic [ST_W-1:0]   state;
    logic [1:0]        pat_r;
    logic [ADDR_W-1:0] lo_r;
    logic [ADDR_W-1:0] hi_r;
    logic              pend_valid;
    logic [ADDR_W-1:0] pend_addr;
    logic              cmp_valid;
    logic [ADDR_W-1:0] cmp_addr;

    logic              idle_like;
    logic              start_acc;
    logic              accept;
    logic              last_addr;
    logic              rd_done;
    logic              mismatch;
    logic [1:0]        wr_pat;
    logic [DATA_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic [DATA_W-1:0] cmp_exp;
    logic [CNT_W-1:0]  err_nxt;

    assign idle_like = (state == ST_IDLE) || (state == ST_DONE);
    assign start_acc = idle_like && start;
    assign accept    = mem && ready;
    assign last_addr = (addr == hi_r);
    // A pending read completes on the first ready edge after its acceptance.
    assign rd_done   = pend_valid && ready;
    assign mismatch  = cmp_valid && (data_s2f_r != cmp_exp);

    // Write data source: first word from the start inputs, later words from the next address.
    always_comb begin
        wr_pat  = idle_like ? pattern : pat_r;
        wr_addr = idle_like ? addr_lo[DATA_W-1:0] : (addr[DATA_W-1:0] + DATA_W'(1));
    end

    // Saturating error count, also used to compute pass on the final compare.
    always_comb begin
        err_nxt = err_count;
        if (mismatch && (err_count != '1)) begin
            err_nxt = err_count + CNT_W'(1);
        end
    end

    sram_bist_pattern #(.DATA_W(DATA_W)) u_wr_pattern (
        .pattern (wr_pat),
        .addr    (wr_addr),
        .data    (wr_data)
    );

    sram_bist_pattern #(.DATA_W(DATA_W)) u_cmp_pattern (
        .pattern (pat_r),
        .addr    (cmp_addr[DATA_W-1:0]),
        .data    (cmp_exp)
    );

    // Main sequencer: request generation and status flags.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= ST_IDLE;
            pat_r    <= PAT_ADDR;
            lo_r     <= '0;
            hi_r     <= '0;
            mem      <= 1'b0;
            rw       <= 1'b1;
            addr     <= '0;
            data_f2s <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            pass     <= 1'b0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        pat_r <= pattern;
                        lo_r  <= addr_lo;
                        hi_r  <= addr_hi;
                        if (addr_lo > addr_hi) begin
                            state <= ST_DONE;
                            done  <= 1'b1;
                            pass  <= 1'b1;
                        end else begin
                            state    <= ST_WRITE;
                            done     <= 1'b0;
                            pass     <= 1'b0;
                            busy     <= 1'b1;
                            mem      <= 1'b1;
                            rw       <= 1'b0;
                            addr     <= addr_lo;
                            data_f2s <= wr_data;
                        end
                    end
                end
                ST_WRITE: begin
                    if (accept) begin
                        if (last_addr) begin
                            state <= ST_READ;
                            rw    <= 1'b1;
                            addr  <= lo_r;
                        end else begin
                            addr     <= addr + ADDR_W'(1);
                            data_f2s <= wr_data;
                        end
                    end
                end
                ST_READ: begin
                    if (accept) begin
                        if (last_addr) begin
                            mem   <= 1'b0;
                            state <= ST_DRAIN;
                        end else begin
                            addr <= addr + ADDR_W'(1);
                        end
                    end
                end
                ST_DRAIN: begin
                    if (cmp_valid && !pend_valid) begin
                        state <= ST_DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        pass  <= (err_nxt == '0);
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Read tracking: one outstanding read, handed to the compare stage on completion.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pend_valid <= 1'b0;
            pend_addr  <= '0;
            cmp_valid  <= 1'b0;
            cmp_addr   <= '0;
        end else begin
            cmp_valid <= rd_done;
            if (rd_done) begin
                cmp_addr <= pend_addr;
            end
            if (accept && rw) begin
                pend_valid <= 1'b1;
                pend_addr  <= addr;
            end else if (rd_done) begin
                pend_valid <= 1'b0;
            end
        end
    end

    // Compare stage: count mismatches and capture the first one.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err_count      <= '0;
            first_err_addr <= '0;
            first_err_data <= '0;
        end else if (start_acc) begin
            err_count      <= '0;
            first_err_addr <= '0;
            first_err_data <= '0;
        end else if (mismatch) begin
            err_count <= err_nxt;
            if (err_count == '0) begin
                first_err_addr <= cmp_addr;
                first_err_data <= data_s2f_r;
            end
        end
    end

endmodule
